// File: rtl/code_defs_pkg.sv
// Shared 64b/66b PCS code definitions.
//   SYNC_DATA / SYNC_CTRL : legal 2-bit sync header values
//   block_lock_state_t    : block-lock controller states
//   is_valid_sh()         : 1 when a sync header is one of the two legal values
package code_defs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [2:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    SLIP,
    SLIP_WAIT_ST
  } block_lock_state_t;

  function automatic logic is_valid_sh(input logic [1:0] header);
    return (header == SYNC_DATA) || (header == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Receive-side block-lock controller for the 64b/66b PCS.
// Watches the sync header on every header-valid cycle, commands gearbox
// bit-slips until the 66-bit boundary is found, then declares and maintains
// block lock (IEEE 802.3 clause 49 lock state machine).
//   i_rxc             : Rx clock
//   i_reset_n         : asynchronous active-low reset
//   i_rx_header       : sync header from the gearbox
//   i_rx_header_valid : i_rx_header is meaningful this cycle (one per block)
//   o_slip            : one-cycle pulse, gearbox shifts alignment by one bit
//   o_block_lock      : block boundary locked
//   o_sh_invalid_cnt  : invalid-header count in the current window
module rx_block_lock
  import code_defs_pkg::*;
#(
  parameter int unsigned SH_CNT_MAX     = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT      = 32
) (
  input  logic       i_rxc,
  input  logic       i_reset_n,
  input  logic [1:0] i_rx_header,
  input  logic       i_rx_header_valid,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic [5:0] o_sh_invalid_cnt
);

  localparam int unsigned CNT_W  = $clog2(SH_CNT_MAX) + 1;
  localparam int unsigned INV_W  = $clog2(SH_INVALID_MAX) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(SLIP_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  block_lock_state_t state_q, state_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              sh_ok;
  logic [CNT_W-1:0]  sh_cnt_inc;
  logic [INV_W-1:0]  inv_cnt_inc;

  assign sh_ok       = is_valid_sh(i_rx_header);
  // Saturating increments; the FSM leaves TEST_SH at the max so these
  // never actually need to wrap.
  assign sh_cnt_inc  = (sh_cnt_q == CNT_MAX) ? sh_cnt_q : sh_cnt_q + 1'b1;
  assign inv_cnt_inc = (inv_cnt_q == INV_MAX) ? inv_cnt_q : inv_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    sh_cnt_d  = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    wait_d    = wait_q;

    case (state_q)
      LOCK_INIT: begin
        lock_d  = 1'b0;
        state_d = RESET_CNT;
      end
      RESET_CNT: begin
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
        state_d   = TEST_SH;
      end
      TEST_SH: begin
        if (i_rx_header_valid) begin
          if (!lock_q) begin
            if (sh_ok) begin
              sh_cnt_d = sh_cnt_inc;
              if (sh_cnt_inc == CNT_MAX) begin
                lock_d  = 1'b1;
                state_d = RESET_CNT;
              end
            end else begin
              state_d = SLIP;
            end
          end else begin
            sh_cnt_d = sh_cnt_inc;
            if (!sh_ok) begin
              inv_cnt_d = inv_cnt_inc;
            end
            // Loss of lock wins over the end-of-window restart.
            if (inv_cnt_d == INV_MAX) begin
              lock_d  = 1'b0;
              state_d = SLIP;
            end else if (sh_cnt_d == CNT_MAX) begin
              state_d = RESET_CNT;
            end
          end
        end
      end
      SLIP: begin
        lock_d  = 1'b0;
        wait_d  = WAIT_LD;
        state_d = SLIP_WAIT_ST;
      end
      SLIP_WAIT_ST: begin
        wait_d = wait_q - 1'b1;
        // Leaving on the 1->0 step gives exactly SLIP_WAIT cycles here.
        if (wait_q <= WAIT_ONE) begin
          state_d = RESET_CNT;
        end
      end
      default: begin
        state_d = LOCK_INIT;
      end
    endcase

    // Registered slip pulse: high for the single cycle spent in SLIP.
    slip_d = (state_d == SLIP);
  end

  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= LOCK_INIT;
      lock_q    <= 1'b0;
      slip_q    <= 1'b0;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      slip_q    <= slip_d;
      sh_cnt_q  <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign o_slip           = slip_q;
  assign o_block_lock     = lock_q;
  assign o_sh_invalid_cnt = 6'(inv_cnt_q);

endmodule
